regfile_mp: RTL

- Parametrised multi-read-port register file with a built-in pending-write scoreboard.
- Successor to the 2R/1W 32x32 register file in the pipelined CPU. Generalised in data width, register count and read-port count.
- Adds an optional same-cycle write-to-read bypass and per-register busy bits so the hazard unit can stall on in-flight loads.
- Sits in ID; the write port is driven from WB; mark requests come from ID/EX on load issue.

---
 rtl/regfile_mp.sv | 59 +++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with optional write bypass and a pending-write busy scoreboard
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     mark_en,
   input  logic [ADDR_W-1:0]        mark_addr,
   output logic [ADDR_W:0]          busy_cnt
);
   localparam int NREG = 1 << ADDR_W;
   logic [DATA_W-1:0] r_mem [NREG];
   logic [NREG-1:0]   r_busy;
   logic [ADDR_W:0]   r_busy_cnt;
   logic              w_wr;
   logic              w_mk;
   logic              w_set;
   logic              w_clr;
   logic [NREG-1:0]   w_busy_nxt;
   assign w_wr = we && (waddr != '0);
   assign w_mk = mark_en && (mark_addr != '0);
   // a mark on the written register keeps it busy, so only a genuine 1->0 or 0->1 moves the count
   assign w_set = w_mk && !r_busy[mark_addr];
   assign w_clr = w_wr && r_busy[waddr] && !(w_mk && (mark_addr == waddr));
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr) w_busy_nxt[waddr] = 1'b0;
      if (w_mk) w_busy_nxt[mark_addr] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) r_mem[i] <= '0;
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (w_wr) r_mem[waddr] <= wdata;
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
      end
   end
   assign busy_cnt = r_busy_cnt;
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_fwd;
      assign w_ra  = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_fwd = (BYPASS != 0) && w_wr && (waddr == w_ra);
      assign rd_data[k*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : w_fwd ? wdata : r_mem[w_ra];
      assign rd_busy[k] = w_fwd ? (w_mk && (mark_addr == w_ra) && r_busy[w_ra]) : r_busy[w_ra];
   end
endmodule
